// File: rtl/v_pipe_sched.sv
// Front-end scheduler for the shared state-table read port: arbitrates queries against a
// small in-order update FIFO, holds queries that collide with pending or in-flight updates.
module v_pipe_sched #(
    parameter int ID_W       = 8,
    parameter int LEVEL_W    = 3,
    parameter int PAYLOAD_W  = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int HAZ_N      = 5,
    parameter int STARVE_N   = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_qry_vld,
    input  logic [ID_W-1:0]                 i_qry_prod_id,
    input  logic [LEVEL_W-1:0]              i_qry_level,
    output logic                            o_qry_rdy,
    input  logic                            i_upd_vld,
    input  logic [ID_W-1:0]                 i_upd_prod_id,
    input  logic [PAYLOAD_W-1:0]            i_upd_payload,
    output logic                            o_upd_rdy,
    output logic                            o_lut_vld_r,
    output logic [ID_W-1:0]                 o_lut_prod_id_r,
    output logic [LEVEL_W-1:0]              o_lut_level_r,
    output logic                            o_upd_vld_r,
    output logic [ID_W-1:0]                 o_upd_prod_id_r,
    output logic [PAYLOAD_W-1:0]            o_upd_payload_r,
    output logic [$clog2(FIFO_DEPTH):0]     o_upd_cnt_r
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SC_W  = $clog2(STARVE_N + 1);

    logic [ID_W-1:0]      fifo_id [FIFO_DEPTH];
    logic [PAYLOAD_W-1:0] fifo_pl [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;

    logic [HAZ_N-1:0]     shadow_vld;
    logic [ID_W-1:0]      shadow_id [HAZ_N];
    logic [SC_W-1:0]      starve_cnt;

    logic push;
    logic qry_haz;
    logic q_ok;
    logic u_ok;
    logic force_u;
    logic grant_q;
    logic grant_u;

    assign o_upd_rdy = (o_upd_cnt_r != CNT_W'(FIFO_DEPTH));
    assign push      = i_upd_vld & o_upd_rdy;

    // A FIFO slot is live when its distance from the read pointer is below the occupancy.
    always_comb begin : haz_p
        logic [PTR_W-1:0] offset;
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        qry_haz = 1'b0;
        offset  = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            offset = PTR_W'(i) - rd_ptr;
            if ((CNT_W'(offset) < o_upd_cnt_r) && (fifo_id[i] == i_qry_prod_id))
                qry_haz = 1'b1;
        end
        for (int i = 0; i < HAZ_N; i++) begin
            if (shadow_vld[i] && (shadow_id[i] == i_qry_prod_id))
                qry_haz = 1'b1;
        end
    end

    always_comb begin
        q_ok    = i_qry_vld & ~qry_haz;
        u_ok    = (o_upd_cnt_r != '0);
        force_u = u_ok & (starve_cnt >= SC_W'(STARVE_N));
        grant_q = q_ok & ~force_u & ~rst;
        grant_u = u_ok & (~q_ok | force_u) & ~rst;
    end

    assign o_qry_rdy = grant_q;

    // NOTE: FIFO storage is not reset; only the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_id[wr_ptr] <= i_upd_prod_id;
            fifo_pl[wr_ptr] <= i_upd_payload;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            o_upd_cnt_r     <= '0;
            starve_cnt      <= '0;
            shadow_vld      <= '0;
            for (int i = 0; i < HAZ_N; i++) shadow_id[i] <= '0;
            o_lut_vld_r     <= 1'b0;
            o_lut_prod_id_r <= '0;
            o_lut_level_r   <= '0;
            o_upd_vld_r     <= 1'b0;
            o_upd_prod_id_r <= '0;
            o_upd_payload_r <= '0;
        end else begin
            if (push)    wr_ptr <= wr_ptr + 1'b1;
            if (grant_u) rd_ptr <= rd_ptr + 1'b1;

            case ({push, grant_u})
                2'b10:   o_upd_cnt_r <= o_upd_cnt_r + 1'b1;
                2'b01:   o_upd_cnt_r <= o_upd_cnt_r - 1'b1;
                default: o_upd_cnt_r <= o_upd_cnt_r;
            endcase

            if (grant_u || !u_ok)
                starve_cnt <= '0;
            else if (starve_cnt != SC_W'(STARVE_N))
                starve_cnt <= starve_cnt + 1'b1;

            // Shadow tracks the issued update through the output register and the update pipe.
            shadow_vld   <= {shadow_vld[HAZ_N-2:0], grant_u};
            shadow_id[0] <= fifo_id[rd_ptr];
            for (int i = 1; i < HAZ_N; i++) shadow_id[i] <= shadow_id[i-1];

            o_lut_vld_r <= grant_q;
            if (grant_q) begin
                o_lut_prod_id_r <= i_qry_prod_id;
                o_lut_level_r   <= i_qry_level;
            end

            o_upd_vld_r <= grant_u;
            if (grant_u) begin
                o_upd_prod_id_r <= fifo_id[rd_ptr];
                o_upd_payload_r <= fifo_pl[rd_ptr];
            end
        end
    end

endmodule

// File: tb/tb_v_pipe_sched.sv
// Scoreboard bench for v_pipe_sched: a queue-based reference model predicts grants and issues,
// a separate monitor pops expectations whenever the DUT issues.
module tb_v_pipe_sched;

    localparam int ID_W       = 8;
    localparam int LEVEL_W    = 3;
    localparam int PAYLOAD_W  = 32;
    localparam int FIFO_DEPTH = 4;
    localparam int HAZ_N      = 5;
    localparam int STARVE_N   = 8;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     i_qry_vld;
    logic [ID_W-1:0]          i_qry_prod_id;
    logic [LEVEL_W-1:0]       i_qry_level;
    logic                     o_qry_rdy;
    logic                     i_upd_vld;
    logic [ID_W-1:0]          i_upd_prod_id;
    logic [PAYLOAD_W-1:0]     i_upd_payload;
    logic                     o_upd_rdy;
    logic                     o_lut_vld_r;
    logic [ID_W-1:0]          o_lut_prod_id_r;
    logic [LEVEL_W-1:0]       o_lut_level_r;
    logic                     o_upd_vld_r;
    logic [ID_W-1:0]          o_upd_prod_id_r;
    logic [PAYLOAD_W-1:0]     o_upd_payload_r;
    logic [$clog2(FIFO_DEPTH):0] o_upd_cnt_r;

    v_pipe_sched #(
        .ID_W(ID_W), .LEVEL_W(LEVEL_W), .PAYLOAD_W(PAYLOAD_W),
        .FIFO_DEPTH(FIFO_DEPTH), .HAZ_N(HAZ_N), .STARVE_N(STARVE_N)
    ) dut (
        .clk(clk), .rst(rst),
        .i_qry_vld(i_qry_vld), .i_qry_prod_id(i_qry_prod_id), .i_qry_level(i_qry_level),
        .o_qry_rdy(o_qry_rdy),
        .i_upd_vld(i_upd_vld), .i_upd_prod_id(i_upd_prod_id), .i_upd_payload(i_upd_payload),
        .o_upd_rdy(o_upd_rdy),
        .o_lut_vld_r(o_lut_vld_r), .o_lut_prod_id_r(o_lut_prod_id_r), .o_lut_level_r(o_lut_level_r),
        .o_upd_vld_r(o_upd_vld_r), .o_upd_prod_id_r(o_upd_prod_id_r),
        .o_upd_payload_r(o_upd_payload_r), .o_upd_cnt_r(o_upd_cnt_r)
    );

    always #5 clk = ~clk;

    typedef struct { logic [ID_W-1:0] id; logic [LEVEL_W-1:0] lvl; int due; } lut_exp_t;
    typedef struct { logic [ID_W-1:0] id; logic [PAYLOAD_W-1:0] pl; int due; } upd_exp_t;
    typedef struct { logic [ID_W-1:0] id; logic [PAYLOAD_W-1:0] pl; } pend_t;

    lut_exp_t exp_lut[$];
    upd_exp_t exp_upd[$];
    pend_t    upd_q[$];
    int       last_grant [256];
    int       lose  = 0;
    int       cyc   = 0;
    int       tests = 0;
    int       fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock of stimulus; the model predicts this cycle's grants from the rules directly.
    task automatic step(input logic r, input logic qv, input logic [ID_W-1:0] qid,
                        input logic [LEVEL_W-1:0] ql, input logic uv,
                        input logic [ID_W-1:0] uid, input logic [PAYLOAD_W-1:0] upl,
                        output logic acc);
        logic haz, qok, uok, frc, gq, gu, full;
        pend_t e;
        rst = r; i_qry_vld = qv; i_qry_prod_id = qid; i_qry_level = ql;
        i_upd_vld = uv; i_upd_prod_id = uid; i_upd_payload = upl;
        @(negedge clk);
        check("upd_cnt", 64'(o_upd_cnt_r), 64'(upd_q.size()));
        acc = 1'b0;
        if (r) begin
            check("qry_rdy_in_rst", 64'(o_qry_rdy), 64'(0));
            upd_q.delete();
            lose = 0;
            foreach (last_grant[k]) last_grant[k] = -1000;
        end else begin
            haz = 1'b0;
            foreach (upd_q[k]) if (upd_q[k].id == qid) haz = 1'b1;
            if ((cyc - last_grant[qid] >= 1) && (cyc - last_grant[qid] <= HAZ_N)) haz = 1'b1;
            qok  = qv && !haz;
            uok  = upd_q.size() != 0;
            frc  = uok && (lose >= STARVE_N);
            gq   = qok && !frc;
            gu   = uok && (!qok || frc);
            full = upd_q.size() == FIFO_DEPTH;
            check("qry_rdy", 64'(o_qry_rdy), 64'(gq));
            check("upd_rdy", 64'(o_upd_rdy), 64'(!full));
            if (gq) exp_lut.push_back('{id: qid, lvl: ql, due: cyc + 1});
            if (gu) begin
                e = upd_q.pop_front();
                exp_upd.push_back('{id: e.id, pl: e.pl, due: cyc + 1});
                last_grant[e.id] = cyc;
            end
            if (uv && !full) upd_q.push_back('{id: uid, pl: upl});
            if (gu || !uok) lose = 0;
            else if (lose < STARVE_N) lose = lose + 1;
            acc = gq;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h0, 3'h0, 1'b0, 8'h0, 32'h0, acc);
    endtask

    // Holds a query until accepted; returns the number of cycles it was refused.
    task automatic qry_hold(input logic [ID_W-1:0] qid, input int bound, output int waited);
        logic acc;
        waited = 0;
        acc    = 1'b0;
        while (!acc && waited <= bound) begin
            step(1'b0, 1'b1, qid, 3'd2, 1'b0, 8'h0, 32'h0, acc);
            if (!acc) waited++;
        end
        check("qry_hold_bound", 64'(waited <= bound), 64'(1));
    endtask

    // Monitor: pops an expectation whenever the DUT presents an issue.
    always @(negedge clk) begin
        lut_exp_t le;
        upd_exp_t ue;
        while (exp_lut.size() > 0 && exp_lut[0].due < cyc) begin
            le = exp_lut.pop_front();
            check("lut_issue_missing", 64'(cyc), 64'(le.due));
        end
        while (exp_upd.size() > 0 && exp_upd[0].due < cyc) begin
            ue = exp_upd.pop_front();
            check("upd_issue_missing", 64'(cyc), 64'(ue.due));
        end
        if (o_lut_vld_r === 1'b1) begin
            if (exp_lut.size() == 0) check("lut_unexpected", 64'(o_lut_vld_r), 64'(0));
            else begin
                le = exp_lut.pop_front();
                check("lut_due", 64'(cyc), 64'(le.due));
                check("lut_id", 64'(o_lut_prod_id_r), 64'(le.id));
                check("lut_level", 64'(o_lut_level_r), 64'(le.lvl));
            end
        end
        if (o_upd_vld_r === 1'b1) begin
            if (exp_upd.size() == 0) check("upd_unexpected", 64'(o_upd_vld_r), 64'(0));
            else begin
                ue = exp_upd.pop_front();
                check("upd_due", 64'(cyc), 64'(ue.due));
                check("upd_id", 64'(o_upd_prod_id_r), 64'(ue.id));
                check("upd_payload", 64'(o_upd_payload_r), 64'(ue.pl));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        int   waited;
        int   rej_idx;
        logic q_pend;
        logic qv;
        logic [ID_W-1:0] qid;
        logic [LEVEL_W-1:0] ql;

        foreach (last_grant[k]) last_grant[k] = -1000;

        // Reset with both requests asserted, then a first query to ID 3.
        step(1'b1, 1'b1, 8'd3, 3'd1, 1'b1, 8'd4, 32'hdead, acc);
        step(1'b1, 1'b1, 8'd3, 3'd1, 1'b1, 8'd4, 32'hdead, acc);
        check("rst_lut_vld", 64'(o_lut_vld_r), 64'(0));
        check("rst_upd_vld", 64'(o_upd_vld_r), 64'(0));
        check("rst_cnt", 64'(o_upd_cnt_r), 64'(0));
        qry_hold(8'd3, 4, waited);
        check("first_qry_no_wait", 64'(waited), 64'(0));
        idle(3);

        // Hazard hold on ID 5; ID 6 unaffected.
        step(1'b0, 1'b0, 8'd0, 3'd0, 1'b1, 8'd5, 32'h55, acc);
        qry_hold(8'd5, 20, waited);
        check("haz_wait_cycles", 64'(waited), 64'(HAZ_N + 1));
        idle(8);
        step(1'b0, 1'b0, 8'd0, 3'd0, 1'b1, 8'd5, 32'h56, acc);
        qry_hold(8'd6, 4, waited);
        check("haz_other_id_no_wait", 64'(waited), 64'(0));
        idle(10);

        // Starvation: query stream to ID 9 against one queued update to ID 1.
        step(1'b0, 1'b1, 8'd9, 3'd3, 1'b1, 8'd1, 32'h11, acc);
        rej_idx = -1;
        for (int i = 1; i <= 12; i++) begin
            step(1'b0, 1'b1, 8'd9, 3'd3, 1'b0, 8'd0, 32'h0, acc);
            if (!acc && rej_idx < 0) rej_idx = i;
        end
        check("starve_force_cycle", 64'(rej_idx), 64'(STARVE_N + 1));
        idle(6);

        // FIFO full: five pushes while queries win; fifth is dropped, payloads drain 1..4.
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b1, 8'd9, 3'd4, 1'b1, 8'(20 + i), 32'(i + 1), acc);
        check("full_cnt", 64'(o_upd_cnt_r), 64'(FIFO_DEPTH));
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 8'd9, 3'd4, 1'b0, 8'd0, 32'h0, acc);
        idle(12);

        // Simultaneous push and pop at cnt = 2.
        step(1'b0, 1'b1, 8'd9, 3'd5, 1'b1, 8'd30, 32'h30, acc);
        step(1'b0, 1'b1, 8'd9, 3'd5, 1'b1, 8'd31, 32'h31, acc);
        step(1'b0, 1'b0, 8'd0, 3'd0, 1'b1, 8'd32, 32'h32, acc);
        check("push_pop_cnt", 64'(o_upd_cnt_r), 64'(2));
        idle(10);

        // Reset mid-operation with populated shadow and cnt = 3.
        step(1'b0, 1'b0, 8'd0, 3'd0, 1'b1, 8'd12, 32'h12, acc);
        step(1'b0, 1'b0, 8'd0, 3'd0, 1'b0, 8'd0, 32'h0, acc);
        step(1'b0, 1'b1, 8'd9, 3'd6, 1'b1, 8'd13, 32'h13, acc);
        step(1'b0, 1'b1, 8'd9, 3'd6, 1'b1, 8'd14, 32'h14, acc);
        step(1'b0, 1'b1, 8'd9, 3'd6, 1'b1, 8'd15, 32'h15, acc);
        check("pre_rst_cnt", 64'(o_upd_cnt_r), 64'(3));
        step(1'b1, 1'b0, 8'd0, 3'd0, 1'b0, 8'd0, 32'h0, acc);
        check("post_rst_cnt", 64'(o_upd_cnt_r), 64'(0));
        qry_hold(8'd12, 4, waited);
        check("post_rst_no_hold", 64'(waited), 64'(0));
        idle(6);

        // Randomized traffic over a small ID space to provoke hazards and forcing.
        q_pend = 1'b0;
        qv = 1'b0; qid = '0; ql = '0;
        for (int i = 0; i < 800; i++) begin
            logic r;
            if (!q_pend) begin
                qv  = ($urandom_range(0, 9) < 6);
                qid = 8'($urandom_range(0, 7));
                ql  = 3'($urandom_range(0, 7));
            end
            r = ($urandom_range(0, 199) == 0);
            step(r, qv, qid, ql, ($urandom_range(0, 9) < 3), 8'($urandom_range(0, 7)),
                 $urandom, acc);
            q_pend = qv && !acc;
        end

        idle(20);
        check("lut_leftover", 64'(exp_lut.size()), 64'(0));
        check("upd_leftover", 64'(exp_upd.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
